// File: rtl/fft_pkg.sv
// Shared constants for the FFT front end: lane geometry, loader states and lane-slice helpers.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fft_pkg;

    localparam int LANES  = 16;               // lanes per beat, fixed by the FFT core
    localparam int DW     = 64;               // sample width {re[31:0], im[31:0]}
    localparam int LANE_W = $clog2(LANES);    // bits of a sample index that select the lane
    localparam int BUS_W  = LANES * DW;       // width of one packed beat

    // Loader sequencing states
    localparam logic [2:0] ST_FILL      = 3'd0;
    localparam logic [2:0] ST_LAUNCH    = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_STREAM    = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE = 3'd4;

    // Lane i of a beat occupies bits [i*DW +: DW]; shared with the result drain stage.
    function automatic logic [DW-1:0] lane_sel(input logic [BUS_W-1:0] bus,
                                               input logic [LANE_W-1:0] idx);
        return bus[int'(idx)*DW +: DW];
    endfunction

endpackage

// File: rtl/fft_frame_loader_if.sv
// Bundle of the loader's sample stream, core start/done handshake and lane bus.
// Latency: n/a (wiring only).
// Backpressure: S_READY from the loader throttles the sample feeder.
// Ports: slave = the loader, master = the feeder/core side driving samples and FFT_DONE.
interface fft_frame_loader_if
    import fft_pkg::*;
    ;
    logic [DW-1:0]    S_DATA;
    logic             S_VALID;
    logic             S_READY;
    logic             FFT_START;
    logic             FFT_DONE;
    logic [BUS_W-1:0] D_LANES;
    logic             BUSY;
    logic             ERR;

    modport slave (
        input  S_DATA, S_VALID, FFT_DONE,
        output S_READY, FFT_START, D_LANES, BUSY, ERR
    );

    modport master (
        output S_DATA, S_VALID, FFT_DONE,
        input  S_READY, FFT_START, D_LANES, BUSY, ERR
    );

endinterface

// File: rtl/fft_frame_buf.sv
// Frame buffer: BEATS x BUS_W memory, one write port, one read port with registered output.
// Latency: read data valid one cycle after rd_addr is presented.
// Backpressure: none; always accepts a write and a read every cycle.
// Ports: clk, wr_en/wr_addr/wr_dat (write side), rd_addr/rd_dat (read side).
module fft_frame_buf
    import fft_pkg::*;
#(
    parameter int BEATS = 256,
    parameter int AW    = $clog2(BEATS)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [BUS_W-1:0] wr_dat,
    input  logic [AW-1:0]    rd_addr,
    output logic [BUS_W-1:0] rd_dat
);

    logic [BUS_W-1:0] mem [BEATS];
    logic [BUS_W-1:0] rd_dat_q;

    // No reset: contents are don't-care until a frame has been written.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
        rd_dat_q <= mem[rd_addr];
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/fft_frame_loader.sv
// Packs a stream of complex samples into 16-lane beats, then plays a whole frame to the FFT core.
// Latency: FFT_START 2 cycles after the last sample is accepted; beat b on D_LANES at +3+b.
// Backpressure: S_READY high only while filling; low from launch until FFT_DONE closes the frame.
// Ports: CLK, RST (async active-high); io.slave carries S_DATA/S_VALID/S_READY, FFT_START/FFT_DONE,
//        D_LANES (lane i at [i*DW +: DW]), BUSY (not filling) and ERR (sticky stray FFT_DONE).
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int BEATS = 256
) (
    input  logic CLK,
    input  logic RST,
    fft_frame_loader_if.slave io
);

    localparam int AW = $clog2(BEATS);
    localparam int CW = $clog2(LANES * BEATS);
    localparam logic [CW-1:0] LAST_K = CW'(LANES * BEATS - 1);

    logic [2:0]                  state_q,   state_d;
    logic [CW-1:0]               cnt_q,     cnt_d;      // sample index within the frame
    logic [AW-1:0]               rd_cnt_q,  rd_cnt_d;   // beats already streamed
    logic [LANES-1:0][DW-1:0]    stage_q,   stage_d;    // one beat being assembled
    logic                        wr_pend_q, wr_pend_d;  // staging holds a complete beat
    logic [AW-1:0]               wr_beat_q, wr_beat_d;
    logic [BUS_W-1:0]            d_lanes_q, d_lanes_d;
    logic                        err_q,     err_d;
    logic                        rdy_q,     rdy_d;

    logic                        accept;
    logic [LANE_W-1:0]           lane;
    logic [AW-1:0]               beat;
    logic [AW-1:0]               rd_addr;
    logic [BUS_W-1:0]            rd_dat;

    assign accept = io.S_VALID && rdy_q && (state_q == ST_FILL);
    assign lane   = cnt_q[LANE_W-1:0];
    assign beat   = cnt_q[CW-1:LANE_W];

    fft_frame_buf #(.BEATS(BEATS), .AW(AW)) u_buf (
        .clk     (CLK),
        .wr_en   (wr_pend_q),
        .wr_addr (wr_beat_q),
        .wr_dat  (stage_q),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_cnt_d  = rd_cnt_q;
        stage_d   = stage_q;
        wr_pend_d = 1'b0;
        wr_beat_d = wr_beat_q;
        d_lanes_d = '0;
        rd_addr   = '0;
        err_d     = err_q || (io.FFT_DONE && (state_q != ST_WAIT_DONE));

        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    stage_d[lane] = io.S_DATA;
                    cnt_d         = cnt_q + CW'(1);
                    // The full beat is copied out next cycle, so lane 0 of the
                    // following beat can be overwritten without stalling.
                    if (lane == LANE_W'(LANES - 1)) begin
                        wr_pend_d = 1'b1;
                        wr_beat_d = beat;
                    end
                    if (cnt_q == LAST_K) begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                // Final beat is being written this cycle; beat 0 read starts in parallel.
                rd_addr  = '0;
                rd_cnt_d = '0;
                state_d  = ST_START;
            end
            ST_START: begin
                rd_addr   = AW'(1);
                d_lanes_d = rd_dat;
                state_d   = ST_STREAM;
            end
            ST_STREAM: begin
                // Reads run two beats ahead of the lane register; the wrapped
                // addresses issued near the end are simply never used.
                rd_addr  = rd_cnt_q + AW'(2);
                rd_cnt_d = rd_cnt_q + AW'(1);
                if (rd_cnt_q == AW'(BEATS - 1)) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    d_lanes_d = rd_dat;
                end
            end
            ST_WAIT_DONE: begin
                if (io.FFT_DONE) begin
                    cnt_d   = '0;
                    state_d = ST_FILL;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        // Registered ready: low throughout reset, high the first cycle after release.
        rdy_d = (state_d == ST_FILL);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_FILL;
            cnt_q     <= '0;
            rd_cnt_q  <= '0;
            stage_q   <= '0;
            wr_pend_q <= 1'b0;
            wr_beat_q <= '0;
            d_lanes_q <= '0;
            err_q     <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            stage_q   <= stage_d;
            wr_pend_q <= wr_pend_d;
            wr_beat_q <= wr_beat_d;
            d_lanes_q <= d_lanes_d;
            err_q     <= err_d;
            rdy_q     <= rdy_d;
        end
    end

    assign io.S_READY   = rdy_q;
    assign io.FFT_START = (state_q == ST_START);
    assign io.D_LANES   = d_lanes_q;
    assign io.BUSY      = (state_q != ST_FILL);
    assign io.ERR       = err_q;

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader with a 4-beat frame (64 samples).
// Latency: checks FFT_START at last accept +2 and beat b at +3+b.
// Backpressure: checks S_READY stays low from launch until FFT_DONE.
module tb_fft_frame_loader;
    import fft_pkg::*;

    localparam int TB_BEATS = 4;
    localparam int NSAMP    = LANES * TB_BEATS;

    typedef logic [BUS_W-1:0] bus_t;

    logic clk;
    logic rst;
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   err_exp = 1'b0;

    fft_frame_loader_if io ();

    fft_frame_loader #(.BEATS(TB_BEATS)) dut (
        .CLK (clk),
        .RST (rst),
        .io  (io)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input bus_t got, input bus_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DW-1:0] samp(input int k);
        logic [31:0] v;
        v = 32'(k);
        return {v, ~v};
    endfunction

    function automatic bus_t exp_beat(input int b);
        bus_t v = '0;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = samp(LANES * b + i);
        return v;
    endfunction

    // Feeds one frame; returns with the bench in the cycle after the last accept.
    task automatic feed(input bit gapped);
        int  k = 0;
        int  guard = 0;
        int  starts = 0;
        bit  ph = 1'b1;
        bit  acc;
        while (k < NSAMP && guard < 1000) begin
            io.S_VALID = gapped ? ph : 1'b1;
            ph         = ~ph;
            io.S_DATA  = samp(k);
            acc        = io.S_VALID && io.S_READY;
            step();
            guard++;
            if (acc) k++;
            if (io.FFT_START) starts++;
        end
        chk("feed_count", bus_t'(k), bus_t'(NSAMP));
        chk("feed_no_start", bus_t'(starts), bus_t'(0));
    endtask

    task automatic run_frame(input bit gapped, input int spur_beat, input int rst_beat);
        int rdy_seen = 0;
        feed(gapped);
        io.S_VALID = 1'b1;
        io.S_DATA  = 64'hDEAD;
        chk("rdy_drop", bus_t'(io.S_READY), bus_t'(0));
        chk("start_t1", bus_t'(io.FFT_START), bus_t'(0));
        step();
        chk("start_t2", bus_t'(io.FFT_START), bus_t'(1));
        for (int b = 0; b < TB_BEATS; b++) begin
            step();
            io.FFT_DONE = 1'b0;
            if (b == rst_beat) begin
                rst = 1'b1;
                err_exp = 1'b0;
                #1;
                chk("rst_async_dl", io.D_LANES, '0);
                step();
                step();
                rst = 1'b0;
                chk("rst_rdy_held", bus_t'(io.S_READY), bus_t'(0));
                step();
                chk("rst_rdy", bus_t'(io.S_READY), bus_t'(1));
                chk("rst_dl", io.D_LANES, '0);
                chk("rst_err", bus_t'(io.ERR), bus_t'(0));
                chk("rst_busy", bus_t'(io.BUSY), bus_t'(0));
                return;
            end
            chk($sformatf("beat%0d", b), io.D_LANES, exp_beat(b));
            chk($sformatf("rdy_stream%0d", b), bus_t'(io.S_READY), bus_t'(0));
            if (b == spur_beat) begin
                io.FFT_DONE = 1'b1;
                err_exp = 1'b1;
            end
        end
        step();
        io.FFT_DONE = 1'b0;
        chk("dl_zero_end", io.D_LANES, '0);
        chk("start_off", bus_t'(io.FFT_START), bus_t'(0));
        chk("err_stream", bus_t'(io.ERR), bus_t'(err_exp));
        for (int c = 0; c < 10; c++) begin
            if (io.S_READY) rdy_seen++;
            step();
        end
        chk("bp_no_ready", bus_t'(rdy_seen), bus_t'(0));
        chk("wait_busy", bus_t'(io.BUSY), bus_t'(1));
        chk("wait_dl", io.D_LANES, '0);
        io.FFT_DONE = 1'b1;
        step();
        io.FFT_DONE = 1'b0;
        chk("done_rdy", bus_t'(io.S_READY), bus_t'(1));
        chk("done_busy", bus_t'(io.BUSY), bus_t'(0));
        chk("err_after", bus_t'(io.ERR), bus_t'(err_exp));
    endtask

    initial begin
        rst         = 1'b1;
        io.S_VALID  = 1'b1;
        io.S_DATA   = samp(0);
        io.FFT_DONE = 1'b0;
        for (int c = 0; c < 3; c++) step();
        chk("rst_ready", bus_t'(io.S_READY), bus_t'(0));
        chk("rst_dlanes", io.D_LANES, '0);
        chk("rst_start", bus_t'(io.FFT_START), bus_t'(0));
        chk("rst_err0", bus_t'(io.ERR), bus_t'(0));
        chk("rst_busy0", bus_t'(io.BUSY), bus_t'(0));
        rst = 1'b0;
        step();
        chk("release_ready", bus_t'(io.S_READY), bus_t'(1));

        run_frame(1'b0, -1, -1);          // continuous, then backpressure in WAIT_DONE
        run_frame(1'b1, 1, -1);           // gapped input, stray FFT_DONE during beat 1
        chk("lane_helper", bus_t'(lane_sel(exp_beat(1), 4'd3)), bus_t'(samp(19)));
        run_frame(1'b0, -1, 2);           // reset during beat 2
        run_frame(1'b0, -1, -1);          // fresh frame after mid-stream reset

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fft_frame_loader.md
Name: fft_frame_loader

Overview:
- Upstream feeder for the 16-lane FFT core.
- Accepts one 64-bit complex sample per cycle over a valid/ready stream and packs samples into 16-lane beats in an internal frame buffer.
- When a full frame is buffered, pulses FFT_START and plays the frame onto the core's lane inputs at one beat per cycle.
- Then waits for FFT_DONE before accepting the next frame.

Parameters:
- LANES, 16, lanes per beat; fixed to match the core.
- DW, 64, sample width: {re[31:0], im[31:0]}.
- BEATS, 256, beats per frame (frame = LANES*BEATS = 4096 samples). Must be a power of two, 2 or more.

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous, active-high reset.
- S_DATA  in  DW  input sample.
- S_VALID  in  1  sample valid.
- S_READY  out  1  loader can accept a sample.
- FFT_START  out  1  one-cycle start pulse to the core.
- FFT_DONE  in  1  core completion pulse.
- D_LANES  out  LANES*DW  lane bus; lane i is bits [i*DW +: DW] and drives core Di.
- BUSY  out  1  high in every state except FILL.
- ERR  out  1  sticky: FFT_DONE seen outside WAIT_DONE.

Behaviour:
- Reset (async assert, deassert synchronised to CLK):
  - Clears state to FILL, all counters, and the staging register.
  - S_READY=0 while RST is high and becomes 1 in the first cycle after release.
  - FFT_START=0, D_LANES=0, BUSY=0, ERR=0.
  - Frame buffer contents are don't-care.
- Sample accept: a sample is taken on a cycle where S_VALID & S_READY. Sample index k (0..LANES*BEATS-1) goes to lane k[3:0] of beat k>>4.
- FILL:
  - S_READY=1.
  - Accepted samples go into a 16-entry staging register.
  - On the cycle after lane 15 is accepted, the staging register is written as one LANES*DW word to buffer[beat]. The staging register is free again in the same cycle, so back-to-back samples never stall.
  - When the accepted sample is k = LANES*BEATS-1: S_READY drops the next cycle, and the state moves to LAUNCH.
- LAUNCH: one cycle. The final beat is written, and read address 0 is issued.
- START: one cycle. FFT_START=1. The registered read of beat 0 completes.
- STREAM:
  - BEATS cycles; beat b is driven on D_LANES in the b-th STREAM cycle.
  - If the last sample is accepted at cycle t: FFT_START is high at t+2, and beat b appears at t+3+b.
  - D_LANES returns to 0 the cycle after beat BEATS-1.
- WAIT_DONE:
  - S_READY=0, D_LANES=0.
  - FFT_DONE=1 sampled here moves the state to FILL; S_READY=1 the next cycle.
- FFT_DONE in any other state: ignored for sequencing, and sets ERR. ERR clears only on RST.
- S_VALID while S_READY=0: no sample is consumed, and the upstream holds S_DATA.
- Wrap-around:
  - The sample counter is log2(LANES*BEATS) bits and resets to 0 on entry to FILL.
  - The beat read counter resets to 0 on entry to START.
- RST mid-frame (any state): partial frame discarded, return to FILL, no FFT_START emitted.
- Buffer: single-port-write / single-port-read array, BEATS x LANES*DW, with registered read. Inferred memory, no reset on the array.

Decomposition:
- Package fft_pkg holds:
  - LANES, DW, the loader state enumeration (FILL, LAUNCH, START, STREAM, WAIT_DONE).
  - The lane-slice helper constants shared with the result drain stage.
- One sub-module: fft_frame_buf (the BEATS x LANES*DW memory with registered read). The FSM, staging register and counters stay in the top of the loader.

Test Plan:
- Reset: RST high 3 cycles with S_VALID=1.
  - During reset: S_READY=0, D_LANES=0, FFT_START=0, ERR=0.
  - After release: S_READY=1 on the first clock.
- Full frame, BEATS=4, continuous S_VALID, sample k = {k,~k}:
  - Exactly 64 samples accepted, then S_READY=0.
  - FFT_START at last accept +2.
  - Beat b lane i = {16b+i, ~(16b+i)} at cycles +3..+6; D_LANES=0 at +7.
- Gapped input, BEATS=4: S_VALID toggles 1/0 every cycle.
  - D_LANES contents identical to the continuous case.
  - FFT_START at last accept +2.
- Backpressure: S_VALID held with S_DATA=0xDEAD in WAIT_DONE for 10 cycles.
  - No samples consumed.
  - After an FFT_DONE pulse, S_READY=1 next cycle; the first accepted sample lands in lane 0 of beat 0.
- Spurious done: FFT_DONE pulsed during STREAM beat 1.
  - ERR=1 and stays 1.
  - Streaming completes all beats, and the state still waits for a later FFT_DONE.
- Reset mid-stream: RST during STREAM beat 2.
  - D_LANES=0 and S_READY=1 after release.
  - No FFT_START until a fresh 64-sample frame is loaded.
